// File: rtl/dmem_bridge.sv
// -----------------------------------------------------------------------------
// dmem_bridge
//
// Data-memory bridge between the core's Memory stage and a valid/ready memory
// bus with variable wait states. Stores are posted into a small write buffer
// and retire without stalling. Loads first let the buffer drain, then issue a
// bus read and return the result on ReadDataM.
//
// Ports
//   clk         pipeline clock, rising edge
//   reset       asynchronous reset, active low (0 = reset)
//   MemWriteM   M-stage store request
//   MemReadM    M-stage load request (never together with MemWriteM)
//   ALUOutM     word-aligned byte address
//   WriteDataM  store data
//   ReadDataM   load result, registered, held until the next read completes
//   MemStall    combinational stall request to the hazard unit
//   BusValid    bus request valid
//   BusWrite    1 = write, 0 = read
//   BusAddr     bus address
//   BusWData    bus write data
//   BusReady    slave accepts/completes the request this cycle
//   BusRData    read data, sampled when BusValid & ~BusWrite & BusReady
//   dbgState    current FSM state (IDLE=0, READ=1, RESP=2)
//   dbgCount    current write-buffer occupancy
//
// Bus handshake: a transfer completes on a rising edge where BusValid and
// BusReady are both 1. Once BusValid is raised it stays high, and BusAddr,
// BusWData and BusWrite stay unchanged, until that completing edge.
// -----------------------------------------------------------------------------
module dmem_bridge #(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         MemWriteM,
    input  logic                         MemReadM,
    input  logic [31:0]                  ALUOutM,
    input  logic [31:0]                  WriteDataM,
    output logic [31:0]                  ReadDataM,
    output logic                         MemStall,
    output logic                         BusValid,
    output logic                         BusWrite,
    output logic [31:0]                  BusAddr,
    output logic [31:0]                  BusWData,
    input  logic                         BusReady,
    input  logic [31:0]                  BusRData,
    output logic [1:0]                   dbgState,
    output logic [$clog2(DEPTH+1)-1:0]   dbgCount
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        RESP = 2'd2
    } stateT;

    stateT state;
    stateT nextState;

    // Write buffer storage and bookkeeping
    logic [31:0]   addrMem [DEPTH];
    logic [31:0]   dataMem [DEPTH];
    logic [PW-1:0] headPtr;
    logic [PW-1:0] tailPtr;
    logic [CW-1:0] count;

    logic fifoEmpty;
    logic fifoFull;
    logic push;
    logic pop;
    logic writeHs;
    logic readHs;

    assign fifoEmpty = (count == '0);
    assign fifoFull  = (count == FULL);

    // Fullness is judged on the count at the start of the cycle, so a store
    // arriving while full waits one cycle even if the head pops right now.
    assign push = MemWriteM & ~fifoFull;

    // Writes are only offered from IDLE; a non-empty buffer keeps the FSM
    // in IDLE, so a drain can never be interrupted by a read.
    assign writeHs = (state == IDLE) & ~fifoEmpty & BusReady;
    assign pop     = writeHs;
    assign readHs  = (state == READ) & BusReady;

    // Gated with reset so the hazard unit sees no stall while in reset.
    assign MemStall = reset & ((MemReadM & (state != RESP)) | (MemWriteM & fifoFull));

    assign dbgState = state;
    assign dbgCount = count;

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next state and bus outputs
    // -------------------------------------------------------------------------
    always_comb begin
        nextState = state;
        BusValid  = 1'b0;
        BusWrite  = 1'b0;
        BusAddr   = '0;
        BusWData  = '0;
        unique case (state)
            IDLE: begin
                if (!fifoEmpty) begin
                    // Drain the head entry; loads wait behind it.
                    BusValid = 1'b1;
                    BusWrite = 1'b1;
                    BusAddr  = addrMem[headPtr];
                    BusWData = dataMem[headPtr];
                end else if (MemReadM) begin
                    nextState = READ;
                end
            end
            READ: begin
                // ALUOutM is held by the core because MemStall is high here.
                BusValid = 1'b1;
                BusAddr  = ALUOutM;
                if (BusReady) begin
                    nextState = RESP;
                end
            end
            RESP: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Write buffer pointers and occupancy
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            headPtr <= '0;
            tailPtr <= '0;
            count   <= '0;
        end else begin
            if (push) begin
                tailPtr <= tailPtr + PW'(1);
            end
            if (pop) begin
                headPtr <= headPtr + PW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage needs no reset: an entry is only read while counted.
    always_ff @(posedge clk) begin
        if (push) begin
            addrMem[tailPtr] <= ALUOutM;
            dataMem[tailPtr] <= WriteDataM;
        end
    end

    // -------------------------------------------------------------------------
    // Load result register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ReadDataM <= '0;
        end else if (readHs) begin
            ReadDataM <= BusRData;
        end
    end

endmodule

// File: tb/tb_dmem_bridge.sv
// -----------------------------------------------------------------------------
// tb_dmem_bridge
//
// Bench for dmem_bridge (DEPTH = 4). Stimulus is driven 1 time unit after the
// rising edge; outputs are sampled on the falling edge. Expected bus writes,
// read addresses and load results are queued when a request is issued and a
// monitor pops and compares them when the DUT presents the matching output.
// -----------------------------------------------------------------------------
module tb_dmem_bridge;

    logic        clk;
    logic        reset;
    logic        MemWriteM;
    logic        MemReadM;
    logic [31:0] ALUOutM;
    logic [31:0] WriteDataM;
    logic [31:0] ReadDataM;
    logic        MemStall;
    logic        BusValid;
    logic        BusWrite;
    logic [31:0] BusAddr;
    logic [31:0] BusWData;
    logic        BusReady;
    logic [31:0] BusRData;
    logic [1:0]  dbgState;
    logic [2:0]  dbgCount;

    int checks = 0;
    int errors = 0;

    logic [63:0] exp_q[$];   // {addr, data} of expected bus writes, in order
    logic [31:0] ra_q[$];    // expected bus read addresses
    logic [31:0] rd_q[$];    // expected ReadDataM values

    // Simple word memory behind the bus; 0x40 is preloaded with a constant.
    logic [31:0] mem [256];

    dmem_bridge #(.DEPTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .MemWriteM  (MemWriteM),
        .MemReadM   (MemReadM),
        .ALUOutM    (ALUOutM),
        .WriteDataM (WriteDataM),
        .ReadDataM  (ReadDataM),
        .MemStall   (MemStall),
        .BusValid   (BusValid),
        .BusWrite   (BusWrite),
        .BusAddr    (BusAddr),
        .BusWData   (BusWData),
        .BusReady   (BusReady),
        .BusRData   (BusRData),
        .dbgState   (dbgState),
        .dbgCount   (dbgCount)
    );

    // ---------------------------------------------------------------- clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ----------------------------------------------------------- bus memory
    assign BusRData = (BusAddr == 32'h40) ? 32'hDEADBEEF : mem[BusAddr[9:2]];

    always @(posedge clk) begin
        if (reset && BusValid && BusWrite && BusReady) begin
            mem[BusAddr[9:2]] <= BusWData;
        end
    end

    // --------------------------------------------------------------- checks
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic at_sample();
        @(negedge clk);
    endtask

    // -------------------------------------------------------------- monitor
    logic        prevPend  = 1'b0;
    logic        prevWrite = 1'b0;
    logic [31:0] prevAddr  = '0;
    logic [31:0] prevData  = '0;

    always @(negedge clk) begin
        if (!reset) begin
            prevPend = 1'b0;
        end else begin
            if (prevPend) begin
                check("hold_valid", 32'(BusValid), 32'd1);
                check("hold_write", 32'(BusWrite), 32'(prevWrite));
                check("hold_addr", BusAddr, prevAddr);
                check("hold_wdata", BusWData, prevData);
            end
            if (BusValid && BusWrite && BusReady) begin
                if (exp_q.size() == 0) begin
                    check("wr_unexpected", BusAddr, 32'hFFFF_FFFF);
                end else begin
                    logic [63:0] e;
                    e = exp_q.pop_front();
                    check("wr_addr", BusAddr, e[63:32]);
                    check("wr_data", BusWData, e[31:0]);
                end
            end
            if (BusValid && !BusWrite && BusReady) begin
                check("rd_order_pending_writes", 32'(exp_q.size()), 32'd0);
                if (ra_q.size() == 0) begin
                    check("rd_unexpected", BusAddr, 32'hFFFF_FFFF);
                end else begin
                    check("rd_addr", BusAddr, ra_q.pop_front());
                end
            end
            if (MemReadM && !MemStall) begin
                if (rd_q.size() == 0) begin
                    check("rdata_unexpected", ReadDataM, 32'hFFFF_FFFF);
                end else begin
                    check("rdata", ReadDataM, rd_q.pop_front());
                end
            end
            prevPend  = BusValid && !BusReady;
            prevWrite = BusWrite;
            prevAddr  = BusAddr;
            prevData  = BusWData;
        end
    end

    // ---------------------------------------------------------- driver tasks
    // Present a store and record its expected bus write (accepted or not yet).
    task automatic issue_store(input logic [31:0] a, input logic [31:0] d);
        MemWriteM  = 1'b1;
        MemReadM   = 1'b0;
        ALUOutM    = a;
        WriteDataM = d;
        exp_q.push_back({a, d});
    endtask

    // Drain the buffer with BusReady held high, bounded.
    task automatic drain(input string name);
        int k;
        MemWriteM = 1'b0;
        BusReady  = 1'b1;
        k = 0;
        while (dbgCount != 3'd0 && k < 50) begin
            next_cycle();
            k++;
        end
        check({name, "_count"}, 32'(dbgCount), 32'd0);
        check({name, "_left"}, 32'(exp_q.size()), 32'd0);
        BusReady = 1'b0;
    endtask

    // Issue a load, keep BusReady low for lowCycles READ cycles, count stalls.
    task automatic run_load(input logic [31:0] a, input logic [31:0] d,
                            input int lowCycles, output int stalls);
        int k;
        MemWriteM = 1'b0;
        MemReadM  = 1'b1;
        ALUOutM   = a;
        BusReady  = (lowCycles == 0);
        ra_q.push_back(a);
        rd_q.push_back(d);
        stalls = 0;
        k = 0;
        while (k < 40) begin
            at_sample();
            if (!MemStall) break;
            stalls++;
            if (BusValid && !BusWrite) check("load_busaddr", BusAddr, a);
            next_cycle();
            BusReady = (k >= lowCycles);
            k++;
        end
        if (k >= 40) check("load_timeout", 32'(k), 32'd0);
        next_cycle();
        MemReadM = 1'b0;
        BusReady = 1'b0;
    endtask

    // ------------------------------------------------------------- stimulus
    initial begin
        int stalls;
        int i;
        int k;

        reset      = 1'b0;
        MemWriteM  = 1'b0;
        MemReadM   = 1'b1;
        ALUOutM    = 32'h100;
        WriteDataM = '0;
        BusReady   = 1'b0;

        // Reset state, with a load presented so the stall gating matters
        next_cycle();
        next_cycle();
        at_sample();
        check("rst_busvalid", 32'(BusValid), 32'd0);
        check("rst_stall", 32'(MemStall), 32'd0);
        check("rst_rdata", ReadDataM, 32'd0);
        check("rst_busaddr", BusAddr, 32'd0);
        check("rst_state", 32'(dbgState), 32'd0);
        check("rst_count", 32'(dbgCount), 32'd0);
        next_cycle();
        MemReadM = 1'b0;
        ALUOutM  = '0;
        reset    = 1'b1;
        next_cycle();

        // Posted stores: four fill the buffer without stalling
        BusReady = 1'b0;
        for (int n = 0; n < 4; n++) begin
            issue_store(32'(32'h10 + 4 * n), 32'(32'hA + n));
            at_sample();
            check("post_stall", 32'(MemStall), 32'd0);
            next_cycle();
        end
        issue_store(32'h30, 32'hE);
        at_sample();
        check("post_count_full", 32'(dbgCount), 32'd4);
        check("post_fifth_stall", 32'(MemStall), 32'd1);
        next_cycle();
        at_sample();
        check("post_fifth_stall2", 32'(MemStall), 32'd1);
        next_cycle();
        BusReady = 1'b1;
        at_sample();
        check("post_stall_on_pop", 32'(MemStall), 32'd1);
        next_cycle();
        BusReady = 1'b0;
        at_sample();
        check("post_accept_stall", 32'(MemStall), 32'd0);
        check("post_count_after_pop", 32'(dbgCount), 32'd3);
        next_cycle();
        MemWriteM = 1'b0;
        at_sample();
        check("post_count_refill", 32'(dbgCount), 32'd4);
        next_cycle();
        drain("post_drain");

        // Load after store: write drains first, then read returns the data
        BusReady = 1'b1;
        issue_store(32'h20, 32'h1234);
        at_sample();
        check("ls_store_stall", 32'(MemStall), 32'd0);
        next_cycle();
        run_load(32'h20, 32'h1234, 0, stalls);

        // Wait states: 3 low cycles in READ -> 5 stall cycles in total
        run_load(32'h40, 32'hDEADBEEF, 3, stalls);
        check("ws_stall_cycles", 32'(stalls), 32'd5);
        next_cycle();
        next_cycle();
        at_sample();
        check("rdata_hold", ReadDataM, 32'hDEADBEEF);
        next_cycle();

        // Full buffer with a store arriving in the same cycle as a pop
        BusReady = 1'b0;
        for (int n = 0; n < 4; n++) begin
            issue_store(32'(32'h50 + 4 * n), 32'(32'h500 + n));
            next_cycle();
        end
        issue_store(32'h60, 32'h66);
        BusReady = 1'b1;
        at_sample();
        check("fp_stall", 32'(MemStall), 32'd1);
        next_cycle();
        BusReady = 1'b0;
        at_sample();
        check("fp_next_stall", 32'(MemStall), 32'd0);
        check("fp_count_mid", 32'(dbgCount), 32'd3);
        next_cycle();
        MemWriteM = 1'b0;
        at_sample();
        check("fp_count_back", 32'(dbgCount), 32'd4);
        next_cycle();
        drain("fp_drain");

        // Wrap-around: 10 stores with random BusReady
        i = 0;
        k = 0;
        while (i < 10 && k < 300) begin
            MemWriteM  = 1'b1;
            MemReadM   = 1'b0;
            ALUOutM    = 32'(32'h200 + 4 * i);
            WriteDataM = 32'(32'hC0DE0000 + i);
            BusReady   = 1'($urandom_range(0, 1));
            at_sample();
            if (!MemStall) begin
                exp_q.push_back({ALUOutM, WriteDataM});
                i++;
            end
            next_cycle();
            k++;
        end
        check("wrap_issued", 32'(i), 32'd10);
        drain("wrap_drain");

        // Reset in the middle of a read
        BusReady = 1'b0;
        MemReadM = 1'b1;
        ALUOutM  = 32'h100;
        next_cycle();
        at_sample();
        check("rr_state_read", 32'(dbgState), 32'd1);
        check("rr_busvalid_pre", 32'(BusValid), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("rr_busvalid", 32'(BusValid), 32'd0);
        check("rr_stall", 32'(MemStall), 32'd0);
        check("rr_rdata", ReadDataM, 32'd0);
        check("rr_state", 32'(dbgState), 32'd0);
        next_cycle();
        MemReadM = 1'b0;
        ALUOutM  = '0;
        next_cycle();
        reset = 1'b1;
        next_cycle();
        at_sample();
        check("rr_after_state", 32'(dbgState), 32'd0);
        check("rr_after_count", 32'(dbgCount), 32'd0);
        check("rr_after_busvalid", 32'(BusValid), 32'd0);
        next_cycle();

        // Reset with stores pending: they are discarded
        issue_store(32'h300, 32'h3);
        next_cycle();
        issue_store(32'h304, 32'h4);
        next_cycle();
        MemWriteM = 1'b0;
        at_sample();
        check("rs_count_pre", 32'(dbgCount), 32'd2);
        #2;
        reset = 1'b0;
        #1;
        exp_q.delete();
        check("rs_count", 32'(dbgCount), 32'd0);
        check("rs_busvalid", 32'(BusValid), 32'd0);
        next_cycle();
        next_cycle();
        reset    = 1'b1;
        BusReady = 1'b1;
        next_cycle();
        at_sample();
        check("rs_after_busvalid", 32'(BusValid), 32'd0);
        check("rs_after_count", 32'(dbgCount), 32'd0);
        next_cycle();
        BusReady = 1'b0;
        next_cycle();

        check("end_wr_queue", 32'(exp_q.size()), 32'd0);
        check("end_rd_queue", 32'(rd_q.size()), 32'd0);
        check("end_ra_queue", 32'(ra_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
